// File: rtl/bool_sweep_ctrl.sv
// Sweeps all 16 input vectors through a 4-input boolean evaluator.
// Captures the truth table and compares it against an expected mask.
module bool_sweep_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] expected,
    output logic [3:0]  eval_in,
    input  logic        eval_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth,
    output logic [4:0]  ones_cnt,
    output logic        mismatch,
    output logic [3:0]  first_fail
);

    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, FINISH} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  cnt_q;
    logic [15:0] exp_q;
    logic [15:0] truth_q;
    logic [4:0]  ones_q;
    logic        mism_q;
    logic [3:0]  ff_q;
    logic        busy_q;
    logic        done_q;
    logic [3:0]  ein_q;

    logic        fail_d;
    logic [3:0]  idx_d;

    assign fail_d = (eval_out != exp_q[idx_q]);
    assign idx_d  = idx_q + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            truth_q <= '0;
            ones_q  <= '0;
            mism_q  <= 1'b0;
            ff_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ein_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        exp_q   <= expected;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        truth_q <= '0;
                        ones_q  <= '0;
                        mism_q  <= 1'b0;
                        ff_q    <= '0;
                        busy_q  <= 1'b1;
                        ein_q   <= '0;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ein_q   <= '0;
                        truth_q <= '0;
                        ones_q  <= '0;
                        mism_q  <= 1'b0;
                        ff_q    <= '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ein_q   <= '0;
                        truth_q <= '0;
                        ones_q  <= '0;
                        mism_q  <= 1'b0;
                        ff_q    <= '0;
                    end else begin
                        truth_q[idx_q] <= eval_out;
                        if (eval_out) begin
                            ones_q <= ones_q + 5'd1;
                        end
                        // Only the lowest failing vector is kept
                        if (fail_d && !mism_q) begin
                            mism_q <= 1'b1;
                            ff_q   <= idx_q;
                        end
                        if (idx_q == 4'd15) begin
                            state_q <= FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            ein_q   <= '0;
                        end else begin
                            idx_q   <= idx_d;
                            ein_q   <= idx_d;
                            cnt_q   <= '0;
                            state_q <= HOLD;
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign eval_in    = ein_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign truth      = truth_q;
    assign ones_cnt   = ones_q;
    assign mismatch   = mism_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_bool_sweep_ctrl.sv
// Bench for bool_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) driving
// table-driven evaluators, compared against a truth-table reference model.
module tb_bool_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start1, abort1, eout1, busy1, done1, mism1;
    logic start3, abort3, eout3, busy3, done3, mism3;
    logic [15:0] exp1, truth1, fn1, exp3, truth3, fn3;
    logic [3:0]  ein1, ff1, ein3, ff3;
    logic [4:0]  ones1, ones3;

    assign eout1 = fn1[ein1];
    assign eout3 = fn3[ein3];

    bool_sweep_ctrl #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .expected(exp1),
        .eval_in(ein1), .eval_out(eout1), .busy(busy1), .done(done1),
        .truth(truth1), .ones_cnt(ones1), .mismatch(mism1), .first_fail(ff1)
    );

    bool_sweep_ctrl #(.SETTLE(3)) u_s3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3), .expected(exp3),
        .eval_in(ein3), .eval_out(eout3), .busy(busy3), .done(done3),
        .truth(truth3), .ones_cnt(ones3), .mismatch(mism3), .first_fail(ff3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  tr_ein   [0:99];
    logic        tr_busy  [0:99];
    logic        tr_done  [0:99];
    logic [15:0] tr_truth [0:99];
    logic [4:0]  tr_ones  [0:99];
    logic        tr_mism  [0:99];
    logic [3:0]  tr_ff    [0:99];

    // Reference model: evaluator abc + a'b' + d, vector k = {a,b,c,d}
    function automatic logic [15:0] ref_table();
        logic [15:0] t;
        bit a, b, c, d;
        t = '0;
        for (int k = 0; k < 16; k++) begin
            a = ((k >> 3) & 1) != 0;
            b = ((k >> 2) & 1) != 0;
            c = ((k >> 1) & 1) != 0;
            d = (k & 1) != 0;
            t[k] = (a & b & c) | (!a & !b) | d;
        end
        return t;
    endfunction

    function automatic int popc(input logic [15:0] v);
        int c = 0;
        for (int k = 0; k < 16; k++) c += int'(v[k]);
        return c;
    endfunction

    function automatic int first_diff(input logic [15:0] x, input logic [15:0] y);
        for (int k = 0; k < 16; k++) if (x[k] !== y[k]) return k;
        return 0;
    endfunction

    function automatic int done_cycle(input int s);
        return 16 * (s + 1) + 1;
    endfunction

    function automatic int done_count(input int budget);
        int c = 0;
        for (int n = 1; n <= budget; n++) if (tr_done[n] === 1'b1) c++;
        return c;
    endfunction

    // Starts a sweep at edge E0 and records outputs for cycles E0+1..E0+budget.
    // Stimulus set at negedge n is sampled at edge E0+n.
    task automatic run_sweep(input bit use3, input logic [15:0] mask, input int budget,
                             input int restart_n, input int abort_n, input int rst_n,
                             input bit hold_start);
        @(negedge clk);
        if (use3) begin start3 = 1'b1; exp3 = mask; end
        else      begin start1 = 1'b1; exp1 = mask; end
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            tr_ein[n]   = use3 ? ein3   : ein1;
            tr_busy[n]  = use3 ? busy3  : busy1;
            tr_done[n]  = use3 ? done3  : done1;
            tr_truth[n] = use3 ? truth3 : truth1;
            tr_ones[n]  = use3 ? ones3  : ones1;
            tr_mism[n]  = use3 ? mism3  : mism1;
            tr_ff[n]    = use3 ? ff3    : ff1;
            if (use3) begin
                start3 = hold_start || (n == restart_n);
                abort3 = (n == abort_n);
                if (n == 1) exp3 = ~mask;
            end else begin
                start1 = hold_start || (n == restart_n);
                abort1 = (n == abort_n);
                if (n == 1) exp1 = ~mask;
            end
            rst = (n == rst_n);
        end
        start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; exp1 = '0; fn1 = 16'hFFFF;
        start3 = 1'b0; abort3 = 1'b0; exp3 = '0; fn3 = 16'hFFFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy1, done1, mism1, ein1, truth1, ones1, ff1} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_s1: busy=%0b done=%0b mism=%0b ein=%0d truth=%h ones=%0d ff=%0d, all required 0",
                     busy1, done1, mism1, ein1, truth1, ones1, ff1);
        end
        n_checks++;
        if ({busy3, done3, mism3, ein3, truth3, ones3, ff3} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_s3: busy=%0b done=%0b mism=%0b ein=%0d truth=%h ones=%0d ff=%0d, all required 0",
                     busy3, done3, mism3, ein3, truth3, ones3, ff3);
        end
    endtask

    task automatic test_reference();
        int dc = done_cycle(1);
        int bad = 0;
        logic [15:0] t = ref_table();
        fn1 = t;
        run_sweep(1'b0, 16'hEAAF, dc + 3, 0, 0, 0, 1'b0);
        n_checks++;
        if (tr_done[dc] !== 1'b1 || done_count(dc + 3) != 1) begin
            n_fail++;
            $display("FAIL ref_done: done@%0d=%0b count=%0d, required 1 and 1", dc, tr_done[dc], done_count(dc + 3));
        end
        n_checks++;
        if (tr_truth[dc] !== t) begin
            n_fail++; $display("FAIL ref_truth: got %h required %h", tr_truth[dc], t);
        end
        n_checks++;
        if (tr_ones[dc] !== 5'(popc(t))) begin
            n_fail++; $display("FAIL ref_ones: got %0d required %0d", tr_ones[dc], popc(t));
        end
        n_checks++;
        if ({tr_mism[dc], tr_ff[dc]} !== 5'd0) begin
            n_fail++; $display("FAIL ref_mism: mism=%0b ff=%0d required 0 0", tr_mism[dc], tr_ff[dc]);
        end
        for (int n = 1; n < dc; n++) begin
            if (tr_ein[n] !== 4'((n - 1) / 2) || tr_busy[n] !== 1'b1) bad++;
        end
        if (tr_busy[dc] !== 1'b0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL ref_seq: %0d cycles with wrong eval_in/busy, required 0", bad);
        end
        n_checks++;
        if (tr_truth[dc + 3] !== t || tr_ones[dc + 3] !== 5'(popc(t))) begin
            n_fail++; $display("FAIL ref_hold: truth=%h ones=%0d required %h %0d", tr_truth[dc + 3], tr_ones[dc + 3], t, popc(t));
        end
    endtask

    task automatic test_wrong_mask();
        int dc = done_cycle(1);
        logic [15:0] t = ref_table();
        fn1 = t;
        run_sweep(1'b0, 16'hEABF, dc + 2, 0, 0, 0, 1'b0);
        n_checks++;
        if (tr_mism[dc] !== 1'b1 || tr_ff[dc] !== 4'(first_diff(t, 16'hEABF))) begin
            n_fail++;
            $display("FAIL wrong_mask: mism=%0b ff=%0d required 1 %0d", tr_mism[dc], tr_ff[dc], first_diff(t, 16'hEABF));
        end
        n_checks++;
        if (tr_truth[dc] !== t) begin
            n_fail++; $display("FAIL wrong_mask_truth: got %h required %h", tr_truth[dc], t);
        end
    endtask

    task automatic test_settle3();
        int dc = done_cycle(3);
        int bad = 0;
        fn3 = 16'hFFFF;
        run_sweep(1'b1, 16'hFFFF, dc + 3, 0, 0, 0, 1'b0);
        n_checks++;
        if (tr_done[dc] !== 1'b1 || done_count(dc + 3) != 1) begin
            n_fail++; $display("FAIL settle3_done: done@%0d=%0b count=%0d required 1 1", dc, tr_done[dc], done_count(dc + 3));
        end
        n_checks++;
        if (tr_truth[dc] !== 16'hFFFF || tr_ones[dc] !== 5'd16 || tr_mism[dc] !== 1'b0) begin
            n_fail++; $display("FAIL settle3_res: truth=%h ones=%0d mism=%0b required ffff 16 0", tr_truth[dc], tr_ones[dc], tr_mism[dc]);
        end
        for (int n = 1; n < dc; n++) if (tr_ein[n] !== 4'((n - 1) / 4)) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL settle3_seq: %0d cycles with wrong eval_in, required 0", bad);
        end
    endtask

    task automatic test_start_ignored();
        int dc = done_cycle(1);
        int bad = 0;
        fn1 = ref_table();
        run_sweep(1'b0, 16'hEAAF, dc + 6, 10, 0, 0, 1'b0);
        n_checks++;
        if (tr_done[dc] !== 1'b1 || done_count(dc + 6) != 1) begin
            n_fail++; $display("FAIL start_ignored_done: done@%0d=%0b count=%0d required 1 1", dc, tr_done[dc], done_count(dc + 6));
        end
        for (int n = 1; n < dc; n++) if (tr_ein[n] !== 4'((n - 1) / 2)) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL start_ignored_seq: %0d cycles with wrong eval_in, required 0", bad);
        end
    endtask

    task automatic test_abort();
        logic [15:0] t;
        int dc = done_cycle(1);
        fn1 = 16'hFFFF;
        run_sweep(1'b0, 16'h0000, 40, 0, 12, 0, 1'b0);
        n_checks++;
        if (tr_ones[12] !== 5'd5 || tr_mism[12] !== 1'b1) begin
            n_fail++; $display("FAIL abort_pre: ones=%0d mism=%0b required 5 1", tr_ones[12], tr_mism[12]);
        end
        n_checks++;
        if ({tr_busy[13], tr_ein[13], tr_truth[13], tr_ones[13], tr_mism[13], tr_ff[13]} !== 31'd0) begin
            n_fail++;
            $display("FAIL abort_clear: busy=%0b ein=%0d truth=%h ones=%0d mism=%0b ff=%0d required all 0",
                     tr_busy[13], tr_ein[13], tr_truth[13], tr_ones[13], tr_mism[13], tr_ff[13]);
        end
        n_checks++;
        if (done_count(40) != 0) begin
            n_fail++; $display("FAIL abort_done: %0d done pulses, required 0", done_count(40));
        end
        t = 16'($urandom);
        fn1 = t;
        run_sweep(1'b0, t, dc + 1, 0, 0, 0, 1'b0);
        n_checks++;
        if (tr_done[dc] !== 1'b1 || tr_truth[dc] !== t || tr_mism[dc] !== 1'b0) begin
            n_fail++; $display("FAIL abort_restart: done=%0b truth=%h mism=%0b required 1 %h 0", tr_done[dc], tr_truth[dc], tr_mism[dc], t);
        end
    endtask

    task automatic test_rst_mid();
        logic [15:0] t;
        int dc = done_cycle(1);
        fn1 = 16'h00FF;
        run_sweep(1'b0, 16'h0F0F, 40, 0, 0, 20, 1'b0);
        n_checks++;
        if ({tr_busy[21], tr_done[21], tr_mism[21], tr_ein[21], tr_truth[21], tr_ones[21], tr_ff[21]} !== 30'd0) begin
            n_fail++;
            $display("FAIL rst_mid: busy=%0b done=%0b mism=%0b ein=%0d truth=%h ones=%0d ff=%0d required all 0",
                     tr_busy[21], tr_done[21], tr_mism[21], tr_ein[21], tr_truth[21], tr_ones[21], tr_ff[21]);
        end
        n_checks++;
        if (done_count(40) != 0) begin
            n_fail++; $display("FAIL rst_mid_done: %0d done pulses, required 0", done_count(40));
        end
        t = 16'($urandom);
        fn1 = t;
        run_sweep(1'b0, ~t, dc + 1, 0, 0, 0, 1'b0);
        n_checks++;
        if (tr_done[dc] !== 1'b1 || tr_truth[dc] !== t || tr_mism[dc] !== 1'b1 || tr_ff[dc] !== 4'd0) begin
            n_fail++; $display("FAIL rst_restart: done=%0b truth=%h mism=%0b ff=%0d required 1 %h 1 0",
                               tr_done[dc], tr_truth[dc], tr_mism[dc], tr_ff[dc], t);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            bit use3 = (it % 3) == 2;
            int s = use3 ? 3 : 1;
            int dc = done_cycle(s);
            logic [15:0] t = 16'($urandom);
            logic [15:0] m = (($urandom & 3) == 0) ? t : t ^ (16'd1 << $urandom_range(15, 0)) ^ 16'($urandom & $urandom);
            bit exp_mism = (t != m);
            if (use3) fn3 = t; else fn1 = t;
            run_sweep(use3, m, dc + 1, 0, 0, 0, 1'b0);
            n_checks++;
            if (tr_done[dc] !== 1'b1 || tr_truth[dc] !== t || tr_ones[dc] !== 5'(popc(t))
                || tr_mism[dc] !== exp_mism || tr_ff[dc] !== 4'(first_diff(t, m))) begin
                n_fail++;
                $display("FAIL random_%0d: done=%0b truth=%h ones=%0d mism=%0b ff=%0d required 1 %h %0d %0b %0d",
                         it, tr_done[dc], tr_truth[dc], tr_ones[dc], tr_mism[dc], tr_ff[dc],
                         t, popc(t), exp_mism, first_diff(t, m));
            end
        end
    endtask

    task automatic test_back_to_back();
        int dc = done_cycle(1);
        logic [15:0] t = 16'($urandom);
        fn1 = t;
        run_sweep(1'b0, t, 2 * dc + 3, 0, 0, 0, 1'b1);
        n_checks++;
        if (tr_done[dc] !== 1'b1 || tr_busy[dc + 1] !== 1'b0 || tr_busy[dc + 2] !== 1'b1 || tr_ein[dc + 2] !== 4'd0) begin
            n_fail++; $display("FAIL b2b_gap: done=%0b busy+1=%0b busy+2=%0b ein+2=%0d required 1 0 1 0",
                               tr_done[dc], tr_busy[dc + 1], tr_busy[dc + 2], tr_ein[dc + 2]);
        end
        n_checks++;
        if (tr_done[2 * dc + 1] !== 1'b1 || done_count(2 * dc + 3) != 2 || tr_truth[2 * dc + 1] !== t) begin
            n_fail++; $display("FAIL b2b_second: done=%0b count=%0d truth=%h required 1 2 %h",
                               tr_done[2 * dc + 1], done_count(2 * dc + 3), tr_truth[2 * dc + 1], t);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reference();
        test_wrong_mask();
        test_settle3();
        test_start_ignored();
        test_abort();
        test_rst_mid();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
